cnt290_seq: RTL and testbench



---
 rtl/cnt290_pkg.sv | 33 +++
 rtl/cnt290_seq_if.sv | 26 ++
 rtl/cnt290_pulse_gen.sv | 73 +++++++
 rtl/cnt290_seq.sv | 152 +++++++++++++++
 tb/tb_cnt290_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnt290_pkg.sv
// Shared types and constants for the ttl74290 command sequencer.
package cnt290_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR    = 2'd0,
        OP_SET9     = 2'd1,
        OP_COUNT    = 2'd2,
        OP_COUNT_TO = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ASSERT,
        S_LOW,
        S_HIGH,
        S_SETTLE,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LOW,
        PH_HIGH
    } phase_e;

    localparam int COUNT_TO_LIMIT = 16;

    function automatic logic is_reset_op(input op_e op);
        return (op == OP_CLEAR) || (op == OP_SET9);
    endfunction

endpackage

// File: rtl/cnt290_seq_if.sv
// Command/status bus between the stimulus master and the counter sequencer.
interface cnt290_seq_if
    import cnt290_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_n;
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       result;

    modport master (
        output cmd_valid, cmd_op, cmd_mode, cmd_n,
        input  cmd_ready, busy, done, err, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mode, cmd_n,
        output cmd_ready, busy, done, err, result
    );
endinterface

// File: rtl/cnt290_pulse_gen.sv
// Generates one low/high count pulse on cpa or cpb per start request.
// A start on the last HIGH cycle chains the next pulse with no idle gap.
module cnt290_pulse_gen
    import cnt290_pkg::*;
#(
    parameter int PULSE_W = 16,
    parameter int GAP_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic sel,
    output logic cpa,
    output logic cpb,
    output logic low_end,
    output logic pulse_done
);
    localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = $clog2(MAXW + 1);

    phase_e          phase, phase_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            cpa_next, cpb_next;

    assign low_end    = (phase == PH_LOW)  && (cnt == '0);
    assign pulse_done = (phase == PH_HIGH) && (cnt == '0);

    always_comb begin
        phase_next = phase;
        cnt_next   = cnt;
        cpa_next   = cpa;
        cpb_next   = cpb;
        if (start) begin
            phase_next = PH_LOW;
            cnt_next   = CW'(PULSE_W - 1);
            cpa_next   = sel;
            cpb_next   = !sel;
        end else begin
            unique case (phase)
                PH_LOW: begin
                    if (cnt == '0) begin
                        phase_next = PH_HIGH;
                        cnt_next   = CW'(GAP_W - 1);
                        cpa_next   = 1'b1;
                        cpb_next   = 1'b1;
                    end else begin
                        cnt_next = cnt - CW'(1);
                    end
                end
                PH_HIGH: begin
                    if (cnt == '0) phase_next = PH_IDLE;
                    else           cnt_next   = cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_IDLE;
            cnt   <= '0;
            cpa   <= 1'b1;
            cpb   <= 1'b1;
        end else begin
            phase <= phase_next;
            cnt   <= cnt_next;
            cpa   <= cpa_next;
            cpb   <= cpb_next;
        end
    end

endmodule

// File: rtl/cnt290_seq.sv
// Command-driven sequencer for a 2-5-10 decade counter: drives mode, reset,
// preset and clock lines for each command and reports the settled count.
module cnt290_seq
    import cnt290_pkg::*;
#(
    parameter int PULSE_W  = 16,
    parameter int GAP_W    = 16,
    parameter int HOLD_W   = 4,
    parameter int SETTLE_W = 2,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    cnt290_seq_if.slave  cmd,
    output logic         s1,
    output logic         s0,
    output logic         r0a,
    output logic         r0b,
    output logic         r9a,
    output logic         r9b,
    output logic         cpa,
    output logic         cpb,
    input  logic         qd,
    input  logic         qc,
    input  logic         qb,
    input  logic         qa
);
    localparam int TMAX = (HOLD_W > SETTLE_W) ? HOLD_W : SETTLE_W;
    localparam int TW   = $clog2(TMAX + 1);

    state_e           state, next_state;
    op_e              op_q;
    logic [3:0]       target;
    logic [CNT_W-1:0] remaining;
    logic [4:0]       pulses;
    logic             err_flag;
    logic [TW-1:0]    timer;
    logic [3:0]       q_in;
    logic             accept, pulse_start, limit_hit, low_end, pulse_done;

    assign q_in          = {qd, qc, qb, qa};
    assign cmd.cmd_ready = (state == S_IDLE) && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    cnt290_pulse_gen #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W)
    ) u_pulse (
        .clk        (clk),
        .rst        (rst),
        .start      (pulse_start),
        .sel        (s0),
        .cpa        (cpa),
        .cpb        (cpb),
        .low_end    (low_end),
        .pulse_done (pulse_done)
    );

    always_comb begin
        next_state  = state;
        pulse_start = 1'b0;
        limit_hit   = 1'b0;
        unique case (state)
            S_IDLE:   if (accept) next_state = S_SETUP;
            S_SETUP: begin
                if (is_reset_op(op_q))                            next_state = S_ASSERT;
                else if (op_q == OP_COUNT && remaining == '0)     next_state = S_SETTLE;
                else if (op_q == OP_COUNT_TO && q_in == target)   next_state = S_SETTLE;
                else begin
                    next_state  = S_LOW;
                    pulse_start = 1'b1;
                end
            end
            S_ASSERT: if (timer == '0) next_state = S_SETTLE;
            S_LOW:    if (low_end)     next_state = S_HIGH;
            // q is only judged once the pulse has fully returned high.
            S_HIGH: begin
                if (pulse_done) begin
                    if (op_q == OP_COUNT) begin
                        if (remaining == CNT_W'(1)) next_state = S_SETTLE;
                        else begin
                            next_state  = S_LOW;
                            pulse_start = 1'b1;
                        end
                    end else if (q_in == target) begin
                        next_state = S_SETTLE;
                    end else if (pulses == 5'(COUNT_TO_LIMIT)) begin
                        next_state = S_SETTLE;
                        limit_hit  = 1'b1;
                    end else begin
                        next_state  = S_LOW;
                        pulse_start = 1'b1;
                    end
                end
            end
            S_SETTLE: if (timer == '0) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_CLEAR;
            target     <= '0;
            remaining  <= '0;
            pulses     <= '0;
            err_flag   <= 1'b0;
            timer      <= '0;
            s1         <= 1'b0;
            s0         <= 1'b0;
            r0a        <= 1'b0;
            r0b        <= 1'b0;
            r9a        <= 1'b0;
            r9b        <= 1'b0;
            cmd.busy   <= 1'b0;
            cmd.done   <= 1'b0;
            cmd.err    <= 1'b0;
            cmd.result <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q      <= cmd.cmd_op;
                target    <= cmd.cmd_n[3:0];
                remaining <= cmd.cmd_n;
                pulses    <= '0;
                err_flag  <= 1'b0;
                {s1, s0}  <= cmd.cmd_mode;
            end
            if (pulse_start) pulses <= pulses + 5'd1;
            if (state == S_HIGH && pulse_done && op_q == OP_COUNT)
                remaining <= remaining - CNT_W'(1);
            if (limit_hit) err_flag <= 1'b1;
            // One shared timer covers both the ASSERT hold and the SETTLE wait.
            if (next_state == S_ASSERT && state != S_ASSERT)      timer <= TW'(HOLD_W - 1);
            else if (next_state == S_SETTLE && state != S_SETTLE) timer <= TW'(SETTLE_W - 1);
            else if (timer != '0)                                 timer <= timer - TW'(1);
            r0a      <= (next_state == S_ASSERT) && (op_q == OP_CLEAR);
            r0b      <= (next_state == S_ASSERT) && (op_q == OP_CLEAR);
            r9a      <= (next_state == S_ASSERT) && (op_q == OP_SET9);
            r9b      <= (next_state == S_ASSERT) && (op_q == OP_SET9);
            cmd.busy <= (next_state != S_IDLE);
            cmd.done <= (next_state == S_DONE);
            if (next_state == S_DONE) begin
                cmd.result <= q_in;
                cmd.err    <= err_flag;
            end
        end
    end

endmodule

// File: tb/tb_cnt290_seq.sv
// Directed bench for cnt290_seq driving a behavioural 2-5-10 counter model.
module tb_cnt290_seq;
    import cnt290_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic s1, s0, r0a, r0b, r9a, r9b, cpa, cpb;
    logic qd, qc, qb, qa;

    cnt290_seq_if #(.CNT_W(8)) cmd_bus ();

    cnt290_seq #(
        .PULSE_W  (16),
        .GAP_W    (16),
        .HOLD_W   (4),
        .SETTLE_W (2),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cmd (cmd_bus),
        .s1  (s1),
        .s0  (s0),
        .r0a (r0a),
        .r0b (r0b),
        .r9a (r9a),
        .r9b (r9b),
        .cpa (cpa),
        .cpb (cpb),
        .qd  (qd),
        .qc  (qc),
        .qb  (qb),
        .qa  (qa)
    );

    always #5 clk = ~clk;

    // Counter model: mode 10 is a full decade on cpa, other cpa modes toggle
    // qa only, and cpb advances the divide-by-5 section on qd..qb.
    logic [3:0] q      = 4'd0;
    logic [2:0] b_tmp;
    logic       prev_a = 1'b1;
    logic       prev_b = 1'b1;
    int         falls_a = 0;
    int         falls_b = 0;

    assign {qd, qc, qb, qa} = q;

    always @(negedge clk) begin
        if (prev_a && !cpa) falls_a++;
        if (prev_b && !cpb) falls_b++;
        if (r0a && r0b) begin
            q = 4'd0;
        end else if (r9a && r9b) begin
            q = 4'd9;
        end else begin
            if (prev_a && !cpa) begin
                if ({s1, s0} == 2'b10) q = (q == 4'd9) ? 4'd0 : q + 4'd1;
                else                   q[0] = ~q[0];
            end
            if (prev_b && !cpb) begin
                b_tmp = q[3:1];
                b_tmp = (b_tmp == 3'd4) ? 3'd0 : b_tmp + 3'd1;
                q[3:1] = b_tmp;
            end
        end
        prev_a = cpa;
        prev_b = cpb;
    end

    int checks = 0;
    int errors = 0;
    int lat, r0c, r9c, fa, fb, lowc, rdy, seen_done, fa0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Issues one command and watches it until done (or a cycle bound),
    // recording latency from the accept edge and line activity seen en route.
    task automatic applyStimulus(input op_e op, input logic [1:0] mode, input logic [7:0] n);
        int guard;
        bit got;
        int fa_start, fb_start;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_mode  = mode;
        cmd_bus.cmd_n     = n;
        guard = 0;
        while (!cmd_bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_bus.cmd_ready) checkOutput("ready_timeout", 0, 1);
        @(posedge clk);
        fa_start = falls_a;
        fb_start = falls_b;
        lat = 0; r0c = 0; r9c = 0; lowc = 0; got = 0;
        for (int k = 1; k <= 10000 && !got; k++) begin
            @(negedge clk);
            if (k == 1) cmd_bus.cmd_valid = 1'b0;
            if (r0a && r0b) r0c++;
            if (r9a && r9b) r9c++;
            if (!cpa) lowc++;
            if (cmd_bus.done) begin
                got = 1;
                lat = k;
            end
        end
        if (!got) checkOutput("done_timeout", 0, 1);
        fa = falls_a - fa_start;
        fb = falls_b - fb_start;
        @(negedge clk);
        rdy = cmd_bus.cmd_ready;
    endtask

    initial begin
        rst               = 1'b1;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = OP_CLEAR;
        cmd_bus.cmd_mode  = 2'b00;
        cmd_bus.cmd_n     = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready",  cmd_bus.cmd_ready, 0);
        checkOutput("rst_busy",   cmd_bus.busy, 0);
        checkOutput("rst_done",   cmd_bus.done, 0);
        checkOutput("rst_err",    cmd_bus.err, 0);
        checkOutput("rst_result", cmd_bus.result, 0);
        checkOutput("rst_ctl",    {s1, s0, r0a, r0b, r9a, r9b, cpa, cpb}, 8'b0000_0011);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", cmd_bus.cmd_ready, 1);

        applyStimulus(OP_CLEAR, 2'b00, 8'd0);
        checkOutput("clr_lat",    lat, 8);
        checkOutput("clr_r0",     r0c, 4);
        checkOutput("clr_r9",     r9c, 0);
        checkOutput("clr_result", cmd_bus.result, 4'b0000);
        checkOutput("clr_ready",  rdy, 1);

        applyStimulus(OP_SET9, 2'b00, 8'd0);
        checkOutput("set9_lat",    lat, 8);
        checkOutput("set9_r9",     r9c, 4);
        checkOutput("set9_r0",     r0c, 0);
        checkOutput("set9_result", cmd_bus.result, 4'b1001);
        checkOutput("set9_err",    cmd_bus.err, 0);

        applyStimulus(OP_CLEAR, 2'b00, 8'd0);
        applyStimulus(OP_COUNT, 2'b10, 8'd7);
        checkOutput("cnt7_lat",    lat, 2 + 7 * 32 + 2);
        checkOutput("cnt7_fa",     fa, 7);
        checkOutput("cnt7_fb",     fb, 0);
        checkOutput("cnt7_low",    lowc, 7 * 16);
        checkOutput("cnt7_result", cmd_bus.result, 4'b0111);

        applyStimulus(OP_CLEAR, 2'b00, 8'd0);
        applyStimulus(OP_COUNT, 2'b01, 8'd5);
        checkOutput("cnt5_lat",    lat, 2 + 5 * 32 + 2);
        checkOutput("cnt5_fb",     fb, 5);
        checkOutput("cnt5_fa",     fa, 0);
        checkOutput("cnt5_low",    lowc, 0);
        checkOutput("cnt5_result", cmd_bus.result, 4'b0000);

        applyStimulus(OP_CLEAR, 2'b00, 8'd0);
        applyStimulus(OP_COUNT_TO, 2'b10, 8'd6);
        checkOutput("to6_lat",    lat, 2 + 6 * 32 + 2);
        checkOutput("to6_fa",     fa, 6);
        checkOutput("to6_err",    cmd_bus.err, 0);
        checkOutput("to6_result", cmd_bus.result, 4'b0110);

        applyStimulus(OP_COUNT_TO, 2'b10, 8'd6);
        checkOutput("to6_again_lat", lat, 4);
        checkOutput("to6_again_fa",  fa, 0);
        checkOutput("to6_again_err", cmd_bus.err, 0);

        applyStimulus(OP_CLEAR, 2'b00, 8'd0);
        applyStimulus(OP_COUNT_TO, 2'b10, 8'd12);
        checkOutput("to12_lat",    lat, 2 + 16 * 32 + 2);
        checkOutput("to12_fa",     fa, 16);
        checkOutput("to12_err",    cmd_bus.err, 1);
        checkOutput("to12_result", cmd_bus.result, 4'b0110);

        applyStimulus(OP_CLEAR, 2'b00, 8'd0);
        checkOutput("clr_err_cleared", cmd_bus.err, 0);
        applyStimulus(OP_COUNT, 2'b00, 8'd255);
        checkOutput("cnt255_fa",     fa, 255);
        checkOutput("cnt255_lat",    lat, 2 + 255 * 32 + 2);
        checkOutput("cnt255_result", cmd_bus.result, 4'b0001);

        // Reset pulse landing in the third LOW phase of a 9-pulse count.
        applyStimulus(OP_CLEAR, 2'b00, 8'd0);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_COUNT;
        cmd_bus.cmd_mode  = 2'b10;
        cmd_bus.cmd_n     = 8'd9;
        @(posedge clk);
        fa0 = falls_a;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        repeat (69) @(negedge clk);
        checkOutput("mid_cpa_low", cpa, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_cpa",   cpa, 1);
        checkOutput("mid_busy",  cmd_bus.busy, 0);
        checkOutput("mid_done",  cmd_bus.done, 0);
        checkOutput("mid_falls", falls_a - fa0, 3);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (cmd_bus.done) seen_done++;
        end
        checkOutput("mid_no_done", seen_done, 0);

        applyStimulus(OP_COUNT, 2'b10, 8'd0);
        checkOutput("cnt0_lat",    lat, 4);
        checkOutput("cnt0_fa",     fa, 0);
        checkOutput("cnt0_result", cmd_bus.result, 4'd3);
        checkOutput("cnt0_err",    cmd_bus.err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
